// File: rtl/cpu_types_pkg.sv
// Shared datapath types.
//   word_t              32-bit machine word
//   mru_state_t         state encoding of mem_response_unit (exported on dbg_state)
//   MRU_TIMEOUT_DEF     default cycles ram_req may wait for ram_ack before ERR
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IACC = 3'd1,
        DACC = 3'd2,
        IHIT = 3'd3,
        DHIT = 3'd4,
        ERR  = 3'd5
    } mru_state_t;

    localparam int MRU_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_response_unit_if.sv
// Bundle of the signals between the request unit, mem_response_unit and RAM.
//   mru : view from mem_response_unit (requests in, hits/loads/RAM request out)
//   tb  : mirror view for whoever drives the datapath and RAM sides
interface mem_response_unit_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  ihit;
    logic  dhit;
    word_t imemload;
    word_t dmemload;
    logic  ram_req;
    logic  ram_wen;
    word_t ram_addr;
    word_t ram_wdata;
    logic  ram_ack;
    word_t ram_rdata;
    logic  mem_error;

    modport mru (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ram_ack, ram_rdata,
        output ihit, dhit, imemload, dmemload,
        output ram_req, ram_wen, ram_addr, ram_wdata, mem_error
    );

    modport tb (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ram_ack, ram_rdata,
        input  ihit, dhit, imemload, dmemload,
        input  ram_req, ram_wen, ram_addr, ram_wdata, mem_error
    );

endinterface

// File: rtl/mem_response_unit_wait_counter.sv
// Saturating wait-cycle counter for an outstanding RAM request.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (has priority over enable)
//   enable     : count one cycle of waiting
//   count      : current count, CW = $clog2(TIMEOUT)+1 bits
//   expired    : count has reached TIMEOUT-1; counting stops there
module wait_counter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          expired
);

    assign expired = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_response_unit.sv
// Memory-side responder for the request unit. Arbitrates level-held fetch and
// data requests onto one RAM port and returns one-cycle ihit/dhit pulses.
//   CLK, nRST                  clock, asynchronous active-low reset
//   imemREN, imemaddr          fetch request (held until ihit)
//   dmemREN, dmemWEN           data read / write request (held until dhit)
//   dmemaddr, dmemstore        data address / write data
//   halt                       blocks new fetches (data still served)
//   ihit, dhit                 one-cycle completion pulses
//   imemload, dmemload         last fetched instruction / last read data
//   ram_req, ram_wen           RAM request and direction
//   ram_addr, ram_wdata        RAM address / write data
//   ram_ack, ram_rdata         RAM completion and read data
//   mem_error                  sticky RAM timeout flag
//   dbg_state, dbg_wait_count  FSM state and wait counter, for observation
//
// RAM handshake: ram_req rises in the cycle after a request is accepted and,
// with ram_wen/ram_addr/ram_wdata, stays constant until a cycle in which
// ram_ack=1; that cycle completes the access (ram_rdata valid with it) and
// ram_req is low in the following cycle. ram_ack while ram_req=0 is ignored.
module mem_response_unit
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = MRU_TIMEOUT_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  imemREN,
    input  word_t                 imemaddr,
    input  logic                  dmemREN,
    input  logic                  dmemWEN,
    input  word_t                 dmemaddr,
    input  word_t                 dmemstore,
    input  logic                  halt,
    output logic                  ihit,
    output logic                  dhit,
    output word_t                 imemload,
    output word_t                 dmemload,
    output logic                  ram_req,
    output logic                  ram_wen,
    output word_t                 ram_addr,
    output word_t                 ram_wdata,
    input  logic                  ram_ack,
    input  word_t                 ram_rdata,
    output logic                  mem_error,
    output mru_state_t            dbg_state,
    output logic [$clog2(TIMEOUT):0] dbg_wait_count
);

    mru_state_t state, next_state;
    logic       wen_q;
    logic       cnt_clear, cnt_en, cnt_expired;
    logic       take_data, take_fetch;
    logic       cap_iload, cap_dload;

    wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
        .clk     (CLK),
        .rst_n   (nRST),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (dbg_wait_count),
        .expired (cnt_expired)
    );

    assign dbg_state = state;

    // Data has strict priority over fetch; halt only gates new fetches.
    assign take_data  = dmemREN | dmemWEN;
    assign take_fetch = imemREN & ~halt;

    always_comb begin
        next_state = state;
        ram_req    = 1'b0;
        ram_wen    = 1'b0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        mem_error  = 1'b0;
        cnt_clear  = 1'b1;
        cnt_en     = 1'b0;
        cap_iload  = 1'b0;
        cap_dload  = 1'b0;
        case (state)
            IDLE: begin
                if (take_data) begin
                    next_state = DACC;
                end else if (take_fetch) begin
                    next_state = IACC;
                end
            end
            IACC: begin
                ram_req   = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (ram_ack) begin
                    // A dropped request still finishes on RAM but gets no hit.
                    if (imemREN) begin
                        next_state = IHIT;
                        cap_iload  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (cnt_expired) begin
                    next_state = ERR;
                end
            end
            DACC: begin
                ram_req   = 1'b1;
                ram_wen   = wen_q;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (ram_ack) begin
                    if (dmemREN | dmemWEN) begin
                        next_state = DHIT;
                        cap_dload  = ~wen_q;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (cnt_expired) begin
                    next_state = ERR;
                end
            end
            IHIT: begin
                ihit       = 1'b1;
                next_state = IDLE;
            end
            DHIT: begin
                dhit       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                mem_error  = 1'b1;
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wen_q     <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            imemload  <= '0;
            dmemload  <= '0;
        end else begin
            state <= next_state;
            // Latch the access parameters only when leaving IDLE so they stay
            // stable for the whole request even if the datapath changes them.
            if (state == IDLE) begin
                if (take_data) begin
                    ram_addr  <= dmemaddr;
                    ram_wdata <= dmemstore;
                    wen_q     <= dmemWEN;
                end else if (take_fetch) begin
                    ram_addr  <= imemaddr;
                    wen_q     <= 1'b0;
                end
            end
            if (cap_iload) begin
                imemload <= ram_rdata;
            end
            if (cap_dload) begin
                dmemload <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_response_unit.sv
module tb_mem_response_unit;
    import cpu_types_pkg::*;

    logic       CLK;
    logic       nRST;
    mru_state_t dbg_state;
    logic [4:0] dbg_wait_count;

    mem_response_unit_if bus ();

    mem_response_unit #(.TIMEOUT(16)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imemREN        (bus.imemREN),
        .imemaddr       (bus.imemaddr),
        .dmemREN        (bus.dmemREN),
        .dmemWEN        (bus.dmemWEN),
        .dmemaddr       (bus.dmemaddr),
        .dmemstore      (bus.dmemstore),
        .halt           (bus.halt),
        .ihit           (bus.ihit),
        .dhit           (bus.dhit),
        .imemload       (bus.imemload),
        .dmemload       (bus.dmemload),
        .ram_req        (bus.ram_req),
        .ram_wen        (bus.ram_wen),
        .ram_addr       (bus.ram_addr),
        .ram_wdata      (bus.ram_wdata),
        .ram_ack        (bus.ram_ack),
        .ram_rdata      (bus.ram_rdata),
        .mem_error      (bus.mem_error),
        .dbg_state      (dbg_state),
        .dbg_wait_count (dbg_wait_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int    errors = 0;
    int    checks = 0;
    word_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic  iren;  word_t iaddr;
        logic  dren;  logic dwen; word_t daddr; word_t dstore;
        logic  halt;  logic ack;  word_t rdata;
        logic  ereq;  logic ewen; word_t eaddr; word_t ewdata;
        logic  eihit; logic edhit; word_t eiload; word_t edload;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iren, input word_t iaddr, input logic dren, input logic dwen,
                       input word_t daddr, input word_t dstore, input logic halt, input logic ack,
                       input word_t rdata, input logic ereq, input logic ewen, input word_t eaddr,
                       input word_t ewdata, input logic eihit, input logic edhit,
                       input word_t eiload, input word_t edload);
        vec_t v;
        v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen; v.daddr = daddr;
        v.dstore = dstore; v.halt = halt; v.ack = ack; v.rdata = rdata;
        v.ereq = ereq; v.ewen = ewen; v.eaddr = eaddr; v.ewdata = ewdata;
        v.eihit = eihit; v.edhit = edhit; v.eiload = eiload; v.edload = edload;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.imemREN   = 1'b0; bus.imemaddr  = '0;
        bus.dmemREN   = 1'b0; bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;   bus.dmemstore = '0;
        bus.halt      = 1'b0;
        bus.ram_ack   = 1'b0; bus.ram_rdata = '0;
    endtask

    // Inputs change and outputs are sampled in the low phase of the clock.
    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge CLK);
        bus.imemREN = v.iren; bus.imemaddr = v.iaddr;
        bus.dmemREN = v.dren; bus.dmemWEN = v.dwen;
        bus.dmemaddr = v.daddr; bus.dmemstore = v.dstore;
        bus.halt = v.halt; bus.ram_ack = v.ack; bus.ram_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d.ram_req", idx), 32'(bus.ram_req), 32'(v.ereq));
        chk($sformatf("v%0d.ram_wen", idx), 32'(bus.ram_wen), 32'(v.ereq & v.ewen));
        if (v.ereq) chk($sformatf("v%0d.ram_addr", idx), bus.ram_addr, v.eaddr);
        if (v.ereq && v.ewen) chk($sformatf("v%0d.ram_wdata", idx), bus.ram_wdata, v.ewdata);
        chk($sformatf("v%0d.ihit", idx), 32'(bus.ihit), 32'(v.eihit));
        chk($sformatf("v%0d.dhit", idx), 32'(bus.dhit), 32'(v.edhit));
        chk($sformatf("v%0d.imemload", idx), bus.imemload, v.eiload);
        chk($sformatf("v%0d.dmemload", idx), bus.dmemload, v.edload);
        chk($sformatf("v%0d.mem_error", idx), 32'(bus.mem_error), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".state"},     32'(dbg_state),     32'(IDLE));
        chk({tag, ".ram_req"},   32'(bus.ram_req),   32'd0);
        chk({tag, ".ram_wen"},   32'(bus.ram_wen),   32'd0);
        chk({tag, ".ram_addr"},  bus.ram_addr,       32'd0);
        chk({tag, ".ram_wdata"}, bus.ram_wdata,      32'd0);
        chk({tag, ".ihit"},      32'(bus.ihit),      32'd0);
        chk({tag, ".dhit"},      32'(bus.dhit),      32'd0);
        chk({tag, ".imemload"},  bus.imemload,       32'd0);
        chk({tag, ".dmemload"},  bus.dmemload,       32'd0);
        chk({tag, ".mem_error"}, 32'(bus.mem_error), 32'd0);
        chk({tag, ".wait_cnt"},  32'(dbg_wait_count), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        word_t exp_w;
        int    waits;

        // Zero-wait read, 0x100 -> 0xDEADBEEF
        add(0,32'h0, 1,0,32'h100,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0, 0,0,32'h0,32'h0);
        add(0,32'h0, 1,0,32'h100,32'h0, 0,1,32'hDEADBEEF, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0);
        add(0,32'h0, 1,0,32'h100,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0, 0,1,32'h0,32'hDEADBEEF);
        add(0,32'h0, 0,0,32'h0,32'h0,   0,0,32'h0,        0,0,32'h0,32'h0, 0,0,32'h0,32'hDEADBEEF);
        // Contention: store 0x1234 @0x200 wins over fetch @0x40
        add(1,32'h40, 0,1,32'h200,32'h1234, 0,0,32'h0,   0,0,32'h0,32'h0,      0,0,32'h0,32'hDEADBEEF);
        add(1,32'h40, 0,1,32'h200,32'h1234, 0,1,32'h0,   1,1,32'h200,32'h1234, 0,0,32'h0,32'hDEADBEEF);
        add(1,32'h40, 0,1,32'h200,32'h1234, 0,0,32'h0,   0,0,32'h0,32'h0,      0,1,32'h0,32'hDEADBEEF);
        add(1,32'h40, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0,      0,0,32'h0,32'hDEADBEEF);
        add(1,32'h40, 0,0,32'h0,32'h0, 0,1,32'hCAFE0001, 1,0,32'h40,32'h0,     0,0,32'h0,32'hDEADBEEF);
        add(1,32'h40, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0,      1,0,32'hCAFE0001,32'hDEADBEEF);
        add(0,32'h0,  0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0,      0,0,32'hCAFE0001,32'hDEADBEEF);
        // Wait states: fetch 0x0, ack on third request cycle
        add(1,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0, 0,0,32'hCAFE0001,32'hDEADBEEF);
        add(1,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,        1,0,32'h0,32'h0, 0,0,32'hCAFE0001,32'hDEADBEEF);
        add(1,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,        1,0,32'h0,32'h0, 0,0,32'hCAFE0001,32'hDEADBEEF);
        add(1,32'h0, 0,0,32'h0,32'h0, 0,1,32'h8C410004, 1,0,32'h0,32'h0, 0,0,32'hCAFE0001,32'hDEADBEEF);
        add(1,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0, 1,0,32'h8C410004,32'hDEADBEEF);
        add(0,32'h0, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0, 0,0,32'h8C410004,32'hDEADBEEF);
        // Halt raised during an in-flight fetch: ihit still issued, next fetch blocked
        add(1,32'h10, 0,0,32'h0,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0,  0,0,32'h8C410004,32'hDEADBEEF);
        add(1,32'h10, 0,0,32'h0,32'h0, 1,0,32'h0,        1,0,32'h10,32'h0, 0,0,32'h8C410004,32'hDEADBEEF);
        add(1,32'h10, 0,0,32'h0,32'h0, 1,1,32'h11112222, 1,0,32'h10,32'h0, 0,0,32'h8C410004,32'hDEADBEEF);
        add(1,32'h14, 0,0,32'h0,32'h0, 1,0,32'h0,        0,0,32'h0,32'h0,  1,0,32'h11112222,32'hDEADBEEF);
        add(1,32'h14, 0,0,32'h0,32'h0, 1,0,32'h0,        0,0,32'h0,32'h0,  0,0,32'h11112222,32'hDEADBEEF);
        add(1,32'h14, 0,0,32'h0,32'h0, 1,0,32'h0,        0,0,32'h0,32'h0,  0,0,32'h11112222,32'hDEADBEEF);
        // Data read still served while halted
        add(1,32'h14, 1,0,32'h104,32'h0, 1,0,32'h0,        0,0,32'h0,32'h0,   0,0,32'h11112222,32'hDEADBEEF);
        add(1,32'h14, 1,0,32'h104,32'h0, 1,1,32'h0BADF00D, 1,0,32'h104,32'h0, 0,0,32'h11112222,32'hDEADBEEF);
        add(1,32'h14, 1,0,32'h104,32'h0, 1,0,32'h0,        0,0,32'h0,32'h0,   0,1,32'h11112222,32'h0BADF00D);
        add(1,32'h14, 0,0,32'h0,32'h0,   1,0,32'h0,        0,0,32'h0,32'h0,   0,0,32'h11112222,32'h0BADF00D);
        add(0,32'h0,  0,0,32'h0,32'h0,   0,0,32'h0,        0,0,32'h0,32'h0,   0,0,32'h11112222,32'h0BADF00D);
        // Dropped data read: access completes, no dhit, load unchanged; stray ack ignored
        add(0,32'h0, 1,0,32'h300,32'h0, 0,0,32'h0,        0,0,32'h0,32'h0,   0,0,32'h11112222,32'h0BADF00D);
        add(0,32'h0, 0,0,32'h300,32'h0, 0,0,32'h0,        1,0,32'h300,32'h0, 0,0,32'h11112222,32'h0BADF00D);
        add(0,32'h0, 0,0,32'h300,32'h0, 0,1,32'h55555555, 1,0,32'h300,32'h0, 0,0,32'h11112222,32'h0BADF00D);
        add(0,32'h0, 0,0,32'h0,32'h0,   0,1,32'hFFFFFFFF, 0,0,32'h0,32'h0,   0,0,32'h11112222,32'h0BADF00D);
        add(0,32'h0, 0,0,32'h0,32'h0,   0,0,32'h0,        0,0,32'h0,32'h0,   0,0,32'h11112222,32'h0BADF00D);

        // Reset
        nRST = 1'b0;
        drive_idle();
        repeat (2) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(i, vecs[i]);
        end

        // Halt with a pending fetch in IDLE: no RAM request for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            drive_idle();
            bus.imemREN = 1'b1; bus.imemaddr = 32'h80; bus.halt = 1'b1;
            #1;
            chk($sformatf("halt_block%0d.ram_req", i), 32'(bus.ram_req), 32'd0);
        end
        @(negedge CLK);
        bus.halt = 1'b0;
        #1;
        chk("unhalt.idle_req", 32'(bus.ram_req), 32'd0);
        @(negedge CLK);
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h00000077;
        #1;
        chk("unhalt.ram_req", 32'(bus.ram_req), 32'd1);
        chk("unhalt.ram_addr", bus.ram_addr, 32'h80);
        @(negedge CLK);
        drive_idle();
        #1;
        chk("unhalt.ihit", 32'(bus.ihit), 32'd1);
        chk("unhalt.imemload", bus.imemload, 32'h00000077);

        // Back-to-back fetches with varying RAM wait states
        for (int n = 0; n < 4; n++) begin
            @(negedge CLK);
            drive_idle();
            bus.imemREN = 1'b1; bus.imemaddr = 32'h1000 + 32'(n * 4);
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                @(negedge CLK);
                #1;
                chk($sformatf("fetch%0d.wait%0d.ram_req", n, w), 32'(bus.ram_req), 32'd1);
                chk($sformatf("fetch%0d.wait%0d.cnt", n, w), 32'(dbg_wait_count), 32'(w));
            end
            @(negedge CLK);
            exp_w = $urandom;
            bus.ram_ack = 1'b1; bus.ram_rdata = exp_w;
            exp_q.push_back(exp_w);
            #1;
            chk($sformatf("fetch%0d.ram_addr", n), bus.ram_addr, 32'h1000 + 32'(n * 4));
            @(negedge CLK);
            bus.ram_ack = 1'b0; bus.ram_rdata = '0;
            #1;
            chk($sformatf("fetch%0d.ihit", n), 32'(bus.ihit), 32'd1);
            if (exp_q.size() > 0) chk($sformatf("fetch%0d.imemload", n), bus.imemload, exp_q.pop_front());
            @(negedge CLK);
            drive_idle();
        end

        // Timeout: fetch never acknowledged
        @(negedge CLK);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h20;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("timeout.req%0d", i), 32'(bus.ram_req), 32'd1);
            chk($sformatf("timeout.cnt%0d", i), 32'(dbg_wait_count), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.ram_ack = 1'b1; bus.ram_rdata = 32'h12345678;
            #1;
            chk($sformatf("err%0d.state", i), 32'(dbg_state), 32'(ERR));
            chk($sformatf("err%0d.mem_error", i), 32'(bus.mem_error), 32'd1);
            chk($sformatf("err%0d.ram_req", i), 32'(bus.ram_req), 32'd0);
            chk($sformatf("err%0d.ihit", i), 32'(bus.ihit), 32'd0);
        end
        @(negedge CLK);
        drive_idle();
        nRST = 1'b0;
        #1;
        chk("err_reset.state", 32'(dbg_state), 32'(IDLE));
        chk("err_reset.mem_error", 32'(bus.mem_error), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Reset mid-access: request drops asynchronously, no dhit afterwards
        @(negedge CLK);
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h400;
        @(negedge CLK);
        #1;
        chk("midrst.pre_req", 32'(bus.ram_req), 32'd1);
        chk("midrst.pre_addr", bus.ram_addr, 32'h400);
        #1;
        nRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        drive_idle();
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("midrst.post%0d.dhit", i), 32'(bus.dhit), 32'd0);
            chk($sformatf("midrst.post%0d.req", i), 32'(bus.ram_req), 32'd0);
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
